// File: rtl/mem_wb_ldq_pkg.sv
// Shared encodings for the MEM/WB load-wait stage: load sizes, stall/write
// polarities, bubble values and the FSM state type.
package mem_wb_ldq_pkg;
  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;

  // Bubble values, cast to the instance widths at the point of use.
  localparam int NOP_REG_ADDR = 0;
  localparam int ZERO_WORD    = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/mem_wb_ldq_ld_extend.sv
// Combinational byte/half/word sign- or zero-extension of lane-aligned load
// data; also usable on the forwarding path.
module ld_extend
  import mem_wb_ldq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] ext
);
  logic [DATA_W-1:0] word_ext;

  // Word loads only need extension when the datapath is wider than 32 bits.
  generate
    if (DATA_W > 32) begin : g_wide
      assign word_ext = {{(DATA_W-32){~uns & data[31]}}, data[31:0]};
    end else begin : g_narrow
      assign word_ext = data[31:0];
    end
  endgenerate

  always_comb begin
    ext = word_ext;
    case (size)
      LD_B:         ext = {{(DATA_W-8){~uns & data[7]}}, data[7:0]};
      LD_H:         ext = {{(DATA_W-16){~uns & data[15]}}, data[15:0]};
      LD_W, 2'b11:  ext = word_ext;
      default:      ext = word_ext;
    endcase
  end
endmodule

// File: rtl/mem_wb_ldq.sv
// MEM/WB pipeline register with a load-wait FSM: forwards ALU results in one
// cycle, parks the destination while a load is outstanding, and watchdogs it.
module mem_wb_ldq
  import mem_wb_ldq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_load,
  input  logic [1:0]            mem_ld_size,
  input  logic                  mem_ld_unsigned,
  input  logic                  mmem_finished,
  input  logic [DATA_W-1:0]     mmem_data,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  wb_busy,
  output logic                  wb_timeout
);
  // TIMEOUT=0 still gets a 1-bit counter so the datapath stays well formed.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [REG_ADDR_W-1:0] wd_d;
  logic                  wreg_d, tmo_d;
  logic [DATA_W-1:0]     wdata_d, ext_data;
  logic                  s, n, stall_unused;

  assign s = stall[STAGE_IDX];
  assign n = stall[STAGE_IDX+1];
  assign stall_unused = ^stall;

  ld_extend #(.DATA_W(DATA_W)) u_ext (
    .data (mmem_data),
    .size (size_q),
    .uns  (uns_q),
    .ext  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wd_d    = wb_wd;
    wreg_d  = wb_wreg;
    wdata_d = wb_wdata;
    tmo_d   = wb_timeout;
    case (state_q)
      ST_IDLE: begin
        if (flush || (s == STOP && n == NO_STOP)) begin
          wd_d    = REG_ADDR_W'(NOP_REG_ADDR);
          wreg_d  = WRITE_DISABLE;
          wdata_d = DATA_W'(ZERO_WORD);
        end else if (s == STOP) begin
          // Downstream is also stopped: hold everything.
        end else if (mem_load) begin
          wd_d    = mem_wd;
          wreg_d  = WRITE_DISABLE;
          size_d  = mem_ld_size;
          uns_d   = mem_ld_unsigned;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          wd_d    = mem_wd;
          wreg_d  = mem_wreg;
          wdata_d = mem_wdata;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          wd_d    = REG_ADDR_W'(NOP_REG_ADDR);
          wreg_d  = WRITE_DISABLE;
          wdata_d = DATA_W'(ZERO_WORD);
          state_d = ST_IDLE;
        end else if (mmem_finished) begin
          wreg_d  = WRITE_ENABLE;
          wdata_d = ext_data;
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          wd_d    = REG_ADDR_W'(NOP_REG_ADDR);
          wreg_d  = WRITE_DISABLE;
          wdata_d = DATA_W'(ZERO_WORD);
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      size_q     <= LD_W;
      uns_q      <= 1'b0;
      wb_wd      <= '0;
      wb_wreg    <= 1'b0;
      wb_wdata   <= '0;
      wb_busy    <= 1'b0;
      wb_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wb_wd      <= wd_d;
      wb_wreg    <= wreg_d;
      wb_wdata   <= wdata_d;
      wb_busy    <= (state_d == ST_WAIT);
      wb_timeout <= tmo_d;
    end
  end
endmodule

// File: tb/tb_mem_wb_ldq.sv
// Directed bench for mem_wb_ldq: expected outputs are queued as stimulus is
// driven and compared one cycle later, after the clock edge.
module tb_mem_wb_ldq;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_load;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_unsigned;
  logic        mmem_finished;
  logic [31:0] mmem_data;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_busy;
  logic        wb_timeout;

  int checks = 0;
  int failures = 0;
  logic exp_tmo = 1'b0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        busy;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_wb_ldq #(.DATA_W(32), .REG_ADDR_W(5), .STALL_W(6), .STAGE_IDX(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_ld_size(mem_ld_size), .mem_ld_unsigned(mem_ld_unsigned),
    .mmem_finished(mmem_finished), .mmem_data(mmem_data), .stall(stall), .flush(flush),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_busy(wb_busy),
    .wb_timeout(wb_timeout)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic chk_data, input logic busy);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk_data;
    e.busy = busy; e.tmo = exp_tmo;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_expectation expected=queued_entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".wd"}, 32'(wb_wd), 32'(e.wd));
      cmp({tag, ".wreg"}, 32'(wb_wreg), 32'(e.wreg));
      if (e.chk_data) cmp({tag, ".wdata"}, wb_wdata, e.wdata);
      cmp({tag, ".busy"}, 32'(wb_busy), 32'(e.busy));
      cmp({tag, ".timeout"}, 32'(wb_timeout), 32'(e.tmo));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic alu(input logic [4:0] wd, input logic wreg, input logic [31:0] d);
    mem_load = 1'b0; mem_wd = wd; mem_wreg = wreg; mem_wdata = d;
  endtask

  // Issue a load; WAIT is entered on the next edge with the destination parked.
  task automatic issue_load(input logic [4:0] wd, input logic [1:0] sz, input logic uns, input string tag);
    mem_load = 1'b1; mem_wd = wd; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    mem_ld_size = sz; mem_ld_unsigned = uns;
    expect_out(wd, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(tag);
    // Garbage on MEM and stall while waiting must be ignored.
    alu(5'd9, 1'b1, 32'h1111_2222);
    stall = 6'b010000;
  endtask

  task automatic finish_load(input logic [4:0] wd, input logic [31:0] d, input logic [31:0] exp, input string tag);
    mmem_finished = 1'b1; mmem_data = d;
    expect_out(wd, 1'b1, exp, 1'b1, 1'b0);
    tick(tag);
    mmem_finished = 1'b0; stall = 6'b0;
  endtask

  task automatic wait_cycles(input logic [4:0] wd, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      expect_out(wd, 1'b0, 32'h0, 1'b0, 1'b1);
      tick(tag);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b0; mmem_finished = 1'b0; mmem_data = '0;
    mem_ld_size = 2'b00; mem_ld_unsigned = 1'b0;
    alu(5'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_now("reset");
    rst = 1'b0;

    alu(5'd5, 1'b1, 32'h1234);
    expect_out(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0);
    tick("alu_pass");

    issue_load(5'd7, 2'b00, 1'b0, "ldb_s_issue");
    wait_cycles(5'd7, 2, "ldb_s_wait");
    finish_load(5'd7, 32'hABCD_0080, 32'hFFFF_FF80, "ldb_s_done");

    issue_load(5'd7, 2'b00, 1'b1, "ldb_u_issue");
    wait_cycles(5'd7, 2, "ldb_u_wait");
    finish_load(5'd7, 32'hABCD_0080, 32'h0000_0080, "ldb_u_done");

    issue_load(5'd8, 2'b01, 1'b0, "ldh_s_issue");
    finish_load(5'd8, 32'h0000_8001, 32'hFFFF_8001, "ldh_s_done");

    issue_load(5'd10, 2'b01, 1'b1, "ldh_u_issue");
    finish_load(5'd10, 32'hFFFF_8001, 32'h0000_8001, "ldh_u_done");

    issue_load(5'd11, 2'b10, 1'b0, "ldw_issue");
    finish_load(5'd11, 32'h89AB_CDEF, 32'h89AB_CDEF, "ldw_done");

    issue_load(5'd0, 2'b11, 1'b1, "ldx0_issue");
    finish_load(5'd0, 32'h0000_0042, 32'h0000_0042, "ldx0_done");

    // Stalls: S=1,N=1 holds; S=1,N=0 bubbles.
    alu(5'd3, 1'b1, 32'h55);
    expect_out(5'd3, 1'b1, 32'h55, 1'b1, 1'b0);
    tick("pre_stall");
    alu(5'd4, 1'b1, 32'h66);
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      expect_out(5'd3, 1'b1, 32'h55, 1'b1, 1'b0);
      tick("stall_hold");
    end
    stall = 6'b010000;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("stall_bubble");
    stall = 6'b0;
    expect_out(5'd4, 1'b1, 32'h66, 1'b1, 1'b0);
    tick("stall_release");

    flush = 1'b1;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("flush_idle");
    flush = 1'b0;

    // Flush beats a simultaneous completion; a later stray completion is ignored.
    issue_load(5'd12, 2'b10, 1'b0, "flush_ld_issue");
    flush = 1'b1; mmem_finished = 1'b1; mmem_data = 32'hCAFE_F00D;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("flush_wait");
    flush = 1'b0; stall = 6'b0;
    alu(5'd2, 1'b1, 32'h77);
    expect_out(5'd2, 1'b1, 32'h77, 1'b1, 1'b0);
    tick("stray_finish");
    mmem_finished = 1'b0;

    // Completion on the would-be timeout cycle wins.
    issue_load(5'd13, 2'b00, 1'b0, "edge_ld_issue");
    wait_cycles(5'd13, 3, "edge_ld_wait");
    finish_load(5'd13, 32'h0000_007F, 32'h0000_007F, "edge_ld_done");

    // Watchdog: 4 WAIT cycles without data.
    issue_load(5'd14, 2'b10, 1'b0, "tmo_issue");
    wait_cycles(5'd14, 3, "tmo_wait");
    exp_tmo = 1'b1;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("tmo_fire");
    stall = 6'b0;

    issue_load(5'd15, 2'b10, 1'b0, "tmo_sticky_issue");
    finish_load(5'd15, 32'h1357_9BDF, 32'h1357_9BDF, "tmo_sticky_done");
    alu(5'd16, 1'b1, 32'hA5);
    expect_out(5'd16, 1'b1, 32'hA5, 1'b1, 1'b0);
    tick("tmo_sticky_alu");

    // Asynchronous reset between edges while waiting.
    issue_load(5'd17, 2'b10, 1'b0, "rst_ld_issue");
    stall = 6'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_tmo = 1'b0;
    expect_out(5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_now("async_rst");
    @(negedge clk);
    rst = 1'b0;
    alu(5'd6, 1'b1, 32'hCAFE);
    expect_out(5'd6, 1'b1, 32'hCAFE, 1'b1, 1'b0);
    tick("post_rst_alu");

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
